i2c_byte_sequencer: RTL and testbench
=====================================

# i2c_byte_sequencer

Single-master I2C byte-level sequencer. It accepts one byte command at a time and generates the START, 8 data bits, ACK slot and STOP on open-drain SCL/SDA. Internally it drives the phase and bit counters that frame each byte, reusing the 9-slot bit-frame counting scheme of the existing bit-frame logic. It sits between the host command logic and the pad-level open-drain drivers.

## Interface

- `CLK_DIV`, default 4: clk cycles per quarter-bit phase; legal range 2..255.

- `clk` input 1: system clock; all state updates on its rising edge.
- `rst` input 1: reset, asynchronous, active-high.
- `cmd_valid` input 1: command present.
- `cmd_ready` output 1: sequencer can accept a command.
- `cmd_start` input 1: emit START or repeated START before the byte.
- `cmd_stop` input 1: emit STOP after the ACK slot.
- `cmd_read` input 1: 1 = read byte from slave; 0 = write `tx_data`.
- `cmd_ack` input 1: ACK value the master sends on a read; 0 = ACK (drive low), 1 = NACK.
- `tx_data` input 8: byte to write, sent MSB first.
- `rsp_valid` output 1: one-clk pulse when the byte's ACK slot completes.
- `rx_data` output 8: byte sampled on a read; valid while `rsp_valid` is high and held afterwards.
- `rx_ack` output 1: SDA level sampled in the ACK slot.
- `arb_lost` output 1: one-clk pulse when arbitration is lost.
- `busy` output 1: high in any state other than IDLE.
- `scl_oe` output 1: 1 = pull SCL low; 0 = release.
- `sda_oe` output 1: 1 = pull SDA low; 0 = release.
- `sda_in` input 1: sampled SDA pad level; already synchronised upstream.

## Operation

- States: IDLE, START, DATA, STOP, HOLD. HOLD means the bus is owned and SCL is held low between bytes.
- Phase counter `q` runs 0..CLK_DIV-1. Quarter phase `p` runs 0..3 and advances when `q==CLK_DIV-1`. Bit counter `b` runs 0..8; b=8 is the ACK slot. `b` wraps to 0 at the end of each byte.
- `cmd_ready`=1 only in IDLE and HOLD. A command is accepted on a clk edge where `cmd_valid && cmd_ready`. All command fields are latched at acceptance.
- In IDLE, `cmd_start` is treated as 1 regardless of its input value.
- In HOLD, an accepted command with `cmd_start=0` goes directly to DATA at b=0, p=0.
- START phases (scl_oe/sda_oe):
  - p0 = 1/0. Entered only from HOLD (repeated START).
  - p1 = 0/0. Entry point from IDLE.
  - p2 = 0/1.
  - p3 = 1/1.
  - START then goes to DATA at b=0.
- DATA bit phases:
  - p0 and p3: scl_oe=1.
  - p1 and p2: scl_oe=0.
  - SDA is constant across all four phases of a bit.
- SDA drive per bit:
  - Write, b<8: `sda_oe = ~tx_data[7-b]`.
  - Read, b<8: `sda_oe = 0`.
  - b=8 on a write: `sda_oe = 0`.
  - b=8 on a read: `sda_oe = ~cmd_ack`.
- Sampling: `sda_in` is sampled on the last clk of p1 (`q==CLK_DIV-1`).
  - Read, b<8: the sample shifts into `rx_data` MSB first.
  - b=8: the sample loads `rx_ack`.
- Arbitration: on a write, b<8, if the driven bit is 1 and the sample is 0:
  - pulse `arb_lost`;
  - release both lines;
  - go to IDLE immediately;
  - do not pulse `rsp_valid`.
- End of byte (b=8, p3, last clk):
  - pulse `rsp_valid`;
  - go to STOP if `cmd_stop` was latched, else go to HOLD.
- STOP phases (scl_oe/sda_oe): p0 = 1/1, p1 = 0/1, p2 = 0/0, p3 = 0/0. STOP then goes to IDLE.
- HOLD: scl_oe=1, sda_oe=0. HOLD lasts indefinitely until a command is accepted.

## Timing

- Reset values:
  - state = IDLE; q = p = b = 0.
  - `scl_oe`, `sda_oe`, `busy`, `rsp_valid`, `arb_lost` = 0.
  - `rx_data` = 8'h00; `rx_ack` = 0.
  - `cmd_ready` = 0 while `rst` is high, and 1 on the first clk after release.
- All outputs are registered.
- Latency from the accepting edge:
  - START from IDLE: 3·CLK_DIV clk.
  - START from HOLD: 4·CLK_DIV clk.
  - Byte including ACK slot: 36·CLK_DIV clk.
  - STOP: 4·CLK_DIV clk.
- `busy` rises on the accepting edge. It falls on the edge that enters IDLE.
- `cmd_ready` falls on the accepting edge and rises again on entry to HOLD or IDLE.
- Commands arriving while `cmd_ready=0` wait; `cmd_valid` must be held until accepted.
- `rsp_valid` coincides with the edge leaving b=8 p3. In HOLD it may be followed by acceptance on the very next edge.
- `rst` mid-transfer immediately releases SCL and SDA. No STOP is generated and the partial byte is discarded.
- Arbitration loss ends the transfer; the next accepted command starts from IDLE.

## Test plan

- **Write 0xA5, START+STOP, CLK_DIV=4, slave drives `sda_in`=0 in the ACK slot.**
  - Required: 9 SCL high pulses; sda_oe pattern 0,1,0,1,1,0,1,0.
  - `rsp_valid` at clk 156 after acceptance, with `rx_ack`=0.
  - `busy` low at clk 172.
- **Read with `cmd_ack`=1 and STOP; slave presents 0x3C.**
  - Required: `rx_data`=8'h3C at the `rsp_valid` pulse.
  - sda_oe=0 throughout the ACK slot (NACK).
- **Write without STOP, then a read with START (repeated START).**
  - Required: HOLD between the bytes with scl_oe=1.
  - Repeated-START p0..p3 sequence is observed; second `rsp_valid` occurs 4·4 + 36·4 clk after the second acceptance.
- **Arbitration: write 0xFF, force `sda_in`=0 at bit 2.**
  - Required: `arb_lost` pulse at the end of p1 of bit 2; scl_oe=sda_oe=0 next clk.
  - No `rsp_valid`; state IDLE.
- **Reset mid-byte: assert `rst` during bit 4.**
  - Required: all outputs 0 within the same clk (asynchronous).
  - `cmd_ready`=1 on the first clk after release.
- **CLK_DIV=2 back-to-back writes from HOLD with `cmd_valid` held high.**
  - Required: each accepted on the clk after `rsp_valid`; no gap longer than 1 clk.

Source files
------------

// File: rtl/i2c_byte_sequencer_if.sv
// Command/response handshake and open-drain pad bundle for i2c_byte_sequencer.
// master: host and pad side (commands, sda_in); slave: the sequencer itself.
interface i2c_byte_sequencer_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_start;
  logic       cmd_stop;
  logic       cmd_read;
  logic       cmd_ack;
  logic [7:0] tx_data;
  logic       rsp_valid;
  logic [7:0] rx_data;
  logic       rx_ack;
  logic       arb_lost;
  logic       busy;
  logic       scl_oe;
  logic       sda_oe;
  logic       sda_in;

  modport master (
    output cmd_valid, cmd_start, cmd_stop,
    output cmd_read, cmd_ack, tx_data, sda_in,
    input  cmd_ready, rsp_valid, rx_data,
    input  rx_ack, arb_lost, busy,
    input  scl_oe, sda_oe
  );

  modport slave (
    input  cmd_valid, cmd_start, cmd_stop,
    input  cmd_read, cmd_ack, tx_data, sda_in,
    output cmd_ready, rsp_valid, rx_data,
    output rx_ack, arb_lost, busy,
    output scl_oe, sda_oe
  );
endinterface

// File: rtl/i2c_byte_sequencer.sv
// Single-master I2C byte sequencer: START, 8 data bits, ACK slot, STOP.
// Ports: clk, rst (async, active-high), bus (i2c_byte_sequencer_if.slave).
module i2c_byte_sequencer #(
  parameter int CLK_DIV = 4
) (
  input logic                 clk,
  input logic                 rst,
  i2c_byte_sequencer_if.slave bus
);
  typedef enum logic [2:0] {
    IDLE, START, DATA, STOP, HOLD
  } state_t;

  localparam logic [7:0] QMAX = 8'(CLK_DIV - 1);

  state_t     r_state, w_state;
  logic [7:0] r_q, w_q;
  logic [1:0] r_p, w_p;
  logic [3:0] r_b, w_b;
  logic       r_stop, w_stop;
  logic       r_read, w_read;
  logic       r_ack, w_ack;
  logic [7:0] r_tx, w_tx;
  logic [7:0] r_rx, w_rx;
  logic       r_rx_ack, w_rx_ack;
  logic       r_scl, w_scl;
  logic       r_sda, w_sda;
  logic       r_rsp, w_rsp;
  logic       r_arb, w_arb;
  logic       r_rdy, r_busy;
  logic       w_acc, w_last, w_smp;
  logic [2:0] w_idx, w_nidx;

  always_comb begin
    w_acc    = bus.cmd_valid && r_rdy;
    w_last   = (r_q == QMAX);
    w_smp    = (r_state == DATA) &&
               (r_p == 2'd1) && w_last;
    w_idx    = 3'd7 - r_b[2:0];
    w_state  = r_state;
    w_q      = w_last ? 8'd0 : r_q + 8'd1;
    w_p      = r_p;
    w_b      = r_b;
    w_stop   = r_stop;
    w_read   = r_read;
    w_ack    = r_ack;
    w_tx     = r_tx;
    w_rx     = r_rx;
    w_rx_ack = r_rx_ack;
    w_rsp    = 1'b0;
    w_arb    = 1'b0;

    if (w_smp) begin
      if (r_b[3])
        w_rx_ack = bus.sda_in;
      else if (r_read)
        w_rx = {r_rx[6:0], bus.sda_in};
      else if (r_tx[w_idx] && !bus.sda_in)
        w_arb = 1'b1;
    end

    if (w_acc) begin
      w_stop = bus.cmd_stop;
      w_read = bus.cmd_read;
      w_ack  = bus.cmd_ack;
      w_tx   = bus.tx_data;
    end

    unique case (r_state)
      IDLE: begin
        w_q = 8'd0;
        if (w_acc) begin
          w_state = START;
          w_p     = 2'd1;
        end
      end
      HOLD: begin
        w_q = 8'd0;
        if (w_acc) begin
          w_p     = 2'd0;
          w_b     = 4'd0;
          w_state = bus.cmd_start ? START : DATA;
        end
      end
      START: begin
        if (w_last) begin
          w_p = r_p + 2'd1;
          if (r_p == 2'd3) begin
            w_state = DATA;
            w_b     = 4'd0;
          end
        end
      end
      DATA: begin
        if (w_arb) begin
          w_state = IDLE;
          w_q     = 8'd0;
          w_p     = 2'd0;
          w_b     = 4'd0;
        end else if (w_last) begin
          w_p = r_p + 2'd1;
          if (r_p == 2'd3) begin
            if (r_b[3]) begin
              w_b     = 4'd0;
              w_rsp   = 1'b1;
              w_state = r_stop ? STOP : HOLD;
            end else begin
              w_b = r_b + 4'd1;
            end
          end
        end
      end
      STOP: begin
        if (w_last) begin
          w_p = r_p + 2'd1;
          if (r_p == 2'd3)
            w_state = IDLE;
        end
      end
      default: w_state = IDLE;
    endcase

    // Pad drive is decoded from the next state so it lands
    // in the same register stage as the state itself.
    w_nidx = 3'd7 - w_b[2:0];
    w_scl  = 1'b0;
    w_sda  = 1'b0;
    unique case (w_state)
      HOLD: w_scl = 1'b1;
      START: begin
        w_scl = ~(w_p[0] ^ w_p[1]);
        w_sda = w_p[1];
      end
      DATA: begin
        w_scl = ~(w_p[0] ^ w_p[1]);
        w_sda = w_b[3] ? (w_read & ~w_ack)
                       : (~w_read & ~w_tx[w_nidx]);
      end
      STOP: begin
        w_scl = (w_p == 2'd0);
        w_sda = ~w_p[1];
      end
      default: begin
        w_scl = 1'b0;
        w_sda = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_q      <= 8'd0;
      r_p      <= 2'd0;
      r_b      <= 4'd0;
      r_stop   <= 1'b0;
      r_read   <= 1'b0;
      r_ack    <= 1'b0;
      r_tx     <= 8'h00;
      r_rx     <= 8'h00;
      r_rx_ack <= 1'b0;
      r_scl    <= 1'b0;
      r_sda    <= 1'b0;
      r_rsp    <= 1'b0;
      r_arb    <= 1'b0;
      r_rdy    <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_state  <= w_state;
      r_q      <= w_q;
      r_p      <= w_p;
      r_b      <= w_b;
      r_stop   <= w_stop;
      r_read   <= w_read;
      r_ack    <= w_ack;
      r_tx     <= w_tx;
      r_rx     <= w_rx;
      r_rx_ack <= w_rx_ack;
      r_scl    <= w_scl;
      r_sda    <= w_sda;
      r_rsp    <= w_rsp;
      r_arb    <= w_arb;
      r_rdy    <= (w_state == IDLE) ||
                  (w_state == HOLD);
      r_busy   <= (w_state != IDLE);
    end
  end

  assign bus.cmd_ready = r_rdy;
  assign bus.busy      = r_busy;
  assign bus.rsp_valid = r_rsp;
  assign bus.arb_lost  = r_arb;
  assign bus.rx_data   = r_rx;
  assign bus.rx_ack    = r_rx_ack;
  assign bus.scl_oe    = r_scl;
  assign bus.sda_oe    = r_sda;
endmodule

// File: tb/tb_i2c_byte_sequencer.sv
// Self-checking bench for i2c_byte_sequencer with a small I2C slave model.
// u_dut runs CLK_DIV=4 against the slave; u_dut2 runs CLK_DIV=2 back-to-back.
`timescale 1ns/1ps
module tb_i2c_byte_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  i2c_byte_sequencer_if bus();
  i2c_byte_sequencer_if bus2();

  i2c_byte_sequencer #(.CLK_DIV(4)) u_dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  i2c_byte_sequencer #(.CLK_DIV(2)) u_dut2 (
    .clk(clk), .rst(rst), .bus(bus2)
  );

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h",
               tag, obs, exp);
    end
  endtask

  typedef enum int {SL_NONE, SL_ACK, SL_READ, SL_ARB} sl_t;
  sl_t        sl_mode = SL_NONE;
  logic [7:0] sl_byte = 8'h00;
  int         sl_cnt = 0;
  logic       sl_on = 1'b0;
  logic       pull;
  logic       p_scl = 1'b1;
  logic       p_sda = 1'b1;
  logic       scl_ln;

  assign pull = sl_on && (
    (sl_mode == SL_ACK && sl_cnt == 8) ||
    (sl_mode == SL_READ && sl_cnt < 8 &&
     !sl_byte[3'(7 - sl_cnt)]) ||
    (sl_mode == SL_ARB && sl_cnt == 2));
  assign bus.sda_in  = ~(bus.sda_oe | pull);
  assign bus2.sda_in = ~bus2.sda_oe;
  assign scl_ln      = ~bus.scl_oe;

  // Slave counts SCL falls; slot 8 is ACK, START primes slot 8.
  always @(negedge clk) begin
    if (p_scl && scl_ln && p_sda && !bus.sda_in) begin
      sl_on  = 1'b1;
      sl_cnt = 8;
    end else if (p_scl && scl_ln && !p_sda && bus.sda_in) begin
      sl_on = 1'b0;
    end else if (p_scl && !scl_ln) begin
      sl_cnt = (sl_cnt == 8) ? 0 : sl_cnt + 1;
    end
    p_scl = scl_ln;
    p_sda = bus.sda_in;
  end

  typedef struct {
    logic       rd;
    logic [7:0] dat;
    logic       ack;
    int         lat;
  } exp_t;
  exp_t sb[$];
  exp_t m_e;

  int         acc_cyc = 0;
  int         rsp_cnt = 0;
  int         arb_cnt = 0;
  int         arb_cyc = 0;
  int         n_hi = 0;
  int         snap_hi = 0;
  logic [8:0] hist = 9'd0;
  logic [8:0] snap_hist = 9'd0;
  logic       p_oe = 1'b0;

  always @(negedge clk) begin
    if (p_oe && !bus.scl_oe) begin
      n_hi++;
      hist = {hist[7:0], bus.sda_oe};
    end
    p_oe = bus.scl_oe;
    if (bus.arb_lost) begin
      arb_cnt++;
      arb_cyc = cyc;
    end
    if (bus.rsp_valid) begin
      rsp_cnt++;
      snap_hi   = n_hi;
      snap_hist = hist;
      if (sb.size() == 0) begin
        chk("rsp_unexpected", 1, 0);
      end else begin
        m_e = sb.pop_front();
        chk("rsp_lat", cyc - acc_cyc, m_e.lat);
        chk("rsp_ack", bus.rx_ack, m_e.ack);
        if (m_e.rd)
          chk("rsp_data", bus.rx_data, m_e.dat);
      end
    end
  end

  task automatic send(input logic st, input logic sp,
                      input logic rd, input logic ak,
                      input logic [7:0] d,
                      input logic [7:0] e_dat,
                      input logic e_ack, input int e_lat);
    int   t = 0;
    exp_t e;
    bus.cmd_start = st;
    bus.cmd_stop  = sp;
    bus.cmd_read  = rd;
    bus.cmd_ack   = ak;
    bus.tx_data   = d;
    bus.cmd_valid = 1'b1;
    while (!bus.cmd_ready && t < 2000) begin
      @(negedge clk);
      t++;
    end
    chk("send_wait", 32'(t < 2000), 1);
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    acc_cyc = cyc;
    n_hi    = 0;
    hist    = 9'd0;
    if (e_lat > 0) begin
      e.rd  = rd;
      e.dat = e_dat;
      e.ack = e_ack;
      e.lat = e_lat;
      sb.push_back(e);
    end
  endtask

  task automatic wait_rsp(input int n, input string tag);
    int t = 0;
    while (rsp_cnt < n && t < 400) begin
      @(negedge clk);
      t++;
    end
    chk(tag, 32'(rsp_cnt >= n), 1);
  endtask

  task automatic wait_idle(input string tag);
    int t = 0;
    while (bus.busy && t < 400) begin
      @(negedge clk);
      t++;
    end
    chk(tag, bus.busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rs;
    int t, nacc, nrsp, la, lr;
    bus.cmd_valid  = 1'b0;
    bus.cmd_start  = 1'b0;
    bus.cmd_stop   = 1'b0;
    bus.cmd_read   = 1'b0;
    bus.cmd_ack    = 1'b0;
    bus.tx_data    = 8'h00;
    bus2.cmd_valid = 1'b0;
    bus2.cmd_start = 1'b0;
    bus2.cmd_stop  = 1'b0;
    bus2.cmd_read  = 1'b0;
    bus2.cmd_ack   = 1'b0;
    bus2.tx_data   = 8'h96;

    #12;
    chk("rst_outs", {bus.scl_oe, bus.sda_oe, bus.busy,
                     bus.rsp_valid, bus.arb_lost, bus.rx_ack}, 0);
    chk("rst_rx", bus.rx_data, 8'h00);
    chk("rst_rdy", bus.cmd_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_rdy_after", bus.cmd_ready, 1);

    sl_mode = SL_ACK;
    send(1, 1, 0, 0, 8'hA5, 8'h00, 0, 156);
    wait_rsp(1, "wr_rsp");
    chk("wr_nhi", snap_hi, 9);
    chk("wr_sda", snap_hist, 9'b010110100);
    wait_idle("wr_idle");
    chk("wr_busy_lat", cyc - acc_cyc, 172);

    sl_mode = SL_READ;
    sl_byte = 8'h3C;
    send(1, 1, 1, 1, 8'h00, 8'h3C, 1, 156);
    wait_rsp(2, "rd_rsp");
    chk("rd_nhi", snap_hi, 9);
    chk("rd_sda", snap_hist, 9'd0);
    wait_idle("rd_idle");
    chk("rd_hold", bus.rx_data, 8'h3C);

    sl_mode = SL_ACK;
    send(1, 0, 0, 0, 8'h5A, 8'h00, 0, 156);
    wait_rsp(3, "hold_rsp");
    repeat (5) @(negedge clk);
    chk("hold_lines", {bus.scl_oe, bus.sda_oe,
                       bus.busy, bus.cmd_ready}, 4'b1011);
    sl_mode = SL_READ;
    sl_byte = 8'hC3;
    send(1, 1, 1, 0, 8'h00, 8'hC3, 0, 160);
    rs = 8'h00;
    for (int i = 0; i < 4; i++) begin
      rs = {rs[5:0], bus.scl_oe, bus.sda_oe};
      repeat (4) @(posedge clk);
      #1;
    end
    chk("rstart_seq", rs, 8'b10_00_01_11);
    wait_rsp(4, "rs_rsp");
    wait_idle("rs_idle");

    sl_mode = SL_ARB;
    send(1, 1, 0, 0, 8'hFF, 8'h00, 0, 0);
    t = 0;
    while (arb_cnt < 1 && t < 400) begin
      @(negedge clk);
      t++;
    end
    sl_mode = SL_NONE;
    chk("arb_seen", arb_cnt, 1);
    chk("arb_lat", arb_cyc - acc_cyc, 52);
    chk("arb_lines", {bus.scl_oe, bus.sda_oe, bus.busy}, 0);
    repeat (200) @(negedge clk);
    chk("arb_norsp", rsp_cnt, 4);
    chk("arb_ready", {bus.cmd_ready, bus.busy}, 2'b10);

    send(1, 1, 0, 0, 8'h00, 8'h00, 1, 156);
    repeat (89) @(posedge clk);
    #2;
    chk("mid_pre", {bus.scl_oe, bus.sda_oe, bus.busy}, 3'b111);
    rst = 1'b1;
    #1;
    chk("mid_rst_outs", {bus.scl_oe, bus.sda_oe, bus.busy,
                         bus.cmd_ready, bus.rsp_valid,
                         bus.arb_lost}, 0);
    chk("mid_rst_rx", bus.rx_data, 8'h00);
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("mid_rst_rdy", bus.cmd_ready, 1);
    repeat (200) @(negedge clk);
    chk("mid_norsp", rsp_cnt, 4);

    nacc = 0;
    nrsp = 0;
    la   = 0;
    lr   = 0;
    t    = 0;
    @(negedge clk);
    bus2.cmd_valid = 1'b1;
    while (nrsp < 3 && t < 1000) begin
      if (bus2.cmd_valid && bus2.cmd_ready) begin
        if (nacc > 0)
          chk("b2b_gap", cyc + 1 - lr, 1);
        la = cyc + 1;
        nacc++;
      end
      @(negedge clk);
      t++;
      if (bus2.rsp_valid) begin
        chk("b2b_lat", cyc - la, (nrsp == 0) ? 78 : 72);
        lr = cyc;
        nrsp++;
        if (nrsp == 3)
          bus2.cmd_valid = 1'b0;
      end
    end
    chk("b2b_count", nrsp, 3);
    chk("b2b_hold", {bus2.scl_oe, bus2.busy}, 2'b11);

    chk("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end
endmodule
